// File: rtl/pong_game_logic.sv
// Pong game-state engine: pad/ball physics, scoring and serve/play/over
// sequencing, advanced once per frame on the falling edge of vertical sync.
module pong_game_logic #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PAD_DISTANCE  = 20,
  parameter int PAD_WIDTH     = 10,
  parameter int PAD_HEIGHT    = 80,
  parameter int BALL_SIZE     = 8,
  parameter int PAD_SPEED     = 4,
  parameter int BALL_SPEED    = 3,
  parameter int SERVE_FRAMES  = 60,
  parameter int WIN_SCORE     = 9
) (
  input  logic       i_clk_vga,
  input  logic       i_rst,
  input  logic       i_vga_vs,
  input  logic       i_btn_l_up,
  input  logic       i_btn_l_dn,
  input  logic       i_btn_r_up,
  input  logic       i_btn_r_dn,
  output logic [8:0] o_pad_left,
  output logic [8:0] o_pad_right,
  output logic [9:0] o_ball_x,
  output logic [8:0] o_ball_y,
  output logic [3:0] o_score_left,
  output logic [3:0] o_score_right,
  output logic       o_point_pulse,
  output logic       o_game_over
);

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [3:0]    C_WIN      = 4'(WIN_SCORE);
  localparam logic [9:0]    C_CX       = 10'(SCREEN_WIDTH / 2);
  localparam logic [8:0]    C_CY       = 9'(SCREEN_HEIGHT / 2);
  localparam logic signed [10:0] C_HB    = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] C_BS    = 11'(BALL_SPEED);
  localparam logic signed [10:0] C_PS    = 11'(PAD_SPEED);
  localparam logic signed [10:0] C_PMIN  = 11'(PAD_HEIGHT / 2);
  localparam logic signed [10:0] C_PMAX  = 11'(SCREEN_HEIGHT - PAD_HEIGHT / 2);
  localparam logic signed [10:0] C_YMAX  = 11'(SCREEN_HEIGHT - BALL_SIZE / 2);
  localparam logic signed [10:0] C_XMAX  = 11'(SCREEN_WIDTH - BALL_SIZE / 2);
  localparam logic signed [10:0] C_LOUT  = 11'(PAD_DISTANCE);
  localparam logic signed [10:0] C_LFACE = 11'(PAD_DISTANCE + PAD_WIDTH);
  localparam logic signed [10:0] C_RFACE = 11'(SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH);
  localparam logic signed [10:0] C_ROUT  = 11'(SCREEN_WIDTH - PAD_DISTANCE);
  localparam logic signed [10:0] C_REACH = 11'((PAD_HEIGHT + BALL_SIZE) / 2);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_OVER} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_btn_m, r_btn_s;
  logic          r_vs_d1, r_vs_d2;
  logic [8:0]    r_pad_l, r_pad_r, r_ball_y;
  logic [9:0]    r_ball_x;
  logic          r_dx, r_dy;
  logic [3:0]    r_score_l, r_score_r;
  logic          r_point, r_over;

  logic                w_tick;
  logic signed [10:0]  w_x, w_y, w_nx, w_ny, w_nx_f, w_dl, w_dr;
  logic                w_dy_n, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic [8:0]          w_pad_l_n, w_pad_r_n;

  function automatic logic [8:0] f_pad(input logic [8:0] y, input logic up, input logic dn);
    logic signed [10:0] v;
    v = signed'({2'b00, y});
    if (up && !dn) begin
      v = v - C_PS;
      if (v < C_PMIN) v = C_PMIN;
    end else if (dn && !up) begin
      v = v + C_PS;
      if (v > C_PMAX) v = C_PMAX;
    end
    return v[8:0];
  endfunction

  always_ff @(posedge i_clk_vga or posedge i_rst) begin
    if (i_rst) begin
      r_btn_m <= '0;
      r_btn_s <= '0;
      r_vs_d1 <= 1'b0;
      r_vs_d2 <= 1'b0;
    end else begin
      r_btn_m <= {i_btn_l_up, i_btn_l_dn, i_btn_r_up, i_btn_r_dn};
      r_btn_s <= r_btn_m;
      r_vs_d1 <= i_vga_vs;
      r_vs_d2 <= r_vs_d1;
    end
  end

  assign w_tick    = r_vs_d2 & ~r_vs_d1;
  assign w_pad_l_n = f_pad(r_pad_l, r_btn_s[3], r_btn_s[2]);
  assign w_pad_r_n = f_pad(r_pad_r, r_btn_s[1], r_btn_s[0]);

  // Collisions are judged against the pads as they were before this tick.
  always_comb begin
    w_x    = signed'({1'b0, r_ball_x});
    w_y    = signed'({2'b00, r_ball_y});
    w_nx   = r_dx ? w_x + C_BS : w_x - C_BS;
    w_ny   = r_dy ? w_y + C_BS : w_y - C_BS;
    w_dy_n = r_dy;
    if (w_ny <= C_HB) begin
      w_ny   = C_HB;
      w_dy_n = 1'b1;
    end else if (w_ny >= C_YMAX) begin
      w_ny   = C_YMAX;
      w_dy_n = 1'b0;
    end
    w_dl = w_ny - signed'({2'b00, r_pad_l});
    w_dr = w_ny - signed'({2'b00, r_pad_r});
    w_hit_l = !r_dx && (w_nx - C_HB <= C_LFACE) && (w_x - C_HB > C_LOUT)
              && (w_dl < C_REACH) && (w_dl > -C_REACH);
    w_hit_r = r_dx && (w_nx + C_HB >= C_RFACE) && (w_x + C_HB < C_ROUT)
              && (w_dr < C_REACH) && (w_dr > -C_REACH);
    w_nx_f   = w_hit_l ? C_LFACE + C_HB : (w_hit_r ? C_RFACE - C_HB : w_nx);
    w_miss_l = (w_nx_f <= C_HB);
    w_miss_r = (w_nx_f >= C_XMAX);
  end

  always_ff @(posedge i_clk_vga or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_SERVE;
      r_cnt     <= '0;
      r_pad_l   <= C_CY;
      r_pad_r   <= C_CY;
      r_ball_x  <= C_CX;
      r_ball_y  <= C_CY;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_score_l <= '0;
      r_score_r <= '0;
      r_point   <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_point <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SERVE: begin
            r_pad_l  <= w_pad_l_n;
            r_pad_r  <= w_pad_r_n;
            r_ball_x <= C_CX;
            r_ball_y <= C_CY;
            if (r_cnt == C_CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= S_PLAY;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_PLAY: begin
            r_pad_l <= w_pad_l_n;
            r_pad_r <= w_pad_r_n;
            r_dy    <= w_dy_n;
            if (w_miss_l || w_miss_r) begin
              r_point  <= 1'b1;
              r_ball_x <= C_CX;
              r_ball_y <= C_CY;
              // Serve heads toward the player who just conceded.
              r_dx     <= w_miss_r;
              if (w_miss_l) begin
                r_score_r <= r_score_r + 4'd1;
                r_over    <= (r_score_r + 4'd1 == C_WIN);
                r_state   <= (r_score_r + 4'd1 == C_WIN) ? S_OVER : S_SERVE;
              end else begin
                r_score_l <= r_score_l + 4'd1;
                r_over    <= (r_score_l + 4'd1 == C_WIN);
                r_state   <= (r_score_l + 4'd1 == C_WIN) ? S_OVER : S_SERVE;
              end
            end else begin
              r_ball_x <= w_nx_f[9:0];
              r_ball_y <= w_ny[8:0];
              if (w_hit_l) r_dx <= 1'b1;
              else if (w_hit_r) r_dx <= 1'b0;
            end
          end
          S_OVER: begin
            if (|r_btn_s) begin
              r_score_l <= '0;
              r_score_r <= '0;
              r_cnt     <= '0;
              r_over    <= 1'b0;
              r_state   <= S_SERVE;
            end
          end
          default: r_state <= S_SERVE;
        endcase
      end
    end
  end

  assign o_pad_left    = r_pad_l;
  assign o_pad_right   = r_pad_r;
  assign o_ball_x      = r_ball_x;
  assign o_ball_y      = r_ball_y;
  assign o_score_left  = r_score_l;
  assign o_score_right = r_score_r;
  assign o_point_pulse = r_point;
  assign o_game_over   = r_over;

endmodule
